// File: rtl/multicycle_main_fsm.sv
// Main control FSM for the multicycle RV32I core: sequences each instruction through
// fetch/decode/execute/memory/writeback, with bus-timeout fault and retired-instruction count.
// Define MAIN_FSM_ILLEGAL_TRAP_EN to trap unknown opcodes into FAULT and expose illegal_op.
module multicycle_main_fsm #(
    parameter int unsigned TIMEOUT  = 16,
    parameter int unsigned TO_CNT_W = 5,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       op,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             PCUpdate,
    output logic             Branch,
    output logic             AdrSrc,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       ImmSrc,
    output logic             bus_fault,
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
    output logic             illegal_op,
`endif
    output logic [CNT_W-1:0] instret
);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWRITE,
        S_MEMWB,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_JAL,
        S_BEQ,
        S_FAULT
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [TO_CNT_W-1:0] wait_q;
    logic [TO_CNT_W-1:0] wait_d;
    logic                wait_inc;
    logic                timeout_hit;
    logic                retire;
    logic                to_fault;
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
    logic                illegal_set;
`endif

    assign timeout_hit = (TIMEOUT != 0) && (wait_q == TO_CNT_W'(TIMEOUT - 1));

    // State, wait counter and sticky status registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            instret   <= '0;
            bus_fault <= 1'b0;
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
            illegal_op <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (retire) begin
                instret <= instret + CNT_W'(1);
            end
            if (to_fault) begin
                bus_fault <= 1'b1;
            end
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
            if (illegal_set) begin
                illegal_op <= 1'b1;
            end
`endif
        end
    end

    // Next-state and Moore control decode; IRWrite/PCUpdate in FETCH are ready-qualified.
    always_comb begin
        state_d   = state_q;
        mem_req   = 1'b0;
        PCUpdate  = 1'b0;
        Branch    = 1'b0;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ALUOp     = 2'b00;
        wait_inc  = 1'b0;
        retire    = 1'b0;
        to_fault  = 1'b0;
        wait_d    = '0;
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
        illegal_set = 1'b0;
`endif

        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                PCUpdate  = mem_ready;
                if (mem_ready) state_d = S_DECODE;
                else           wait_inc = 1'b1;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTER;
                    OP_I:         state_d = S_EXECUTEI;
                    OP_JAL:       state_d = S_JAL;
                    OP_BEQ:       state_d = S_BEQ;
                    default: begin
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
                        state_d     = S_FAULT;
                        illegal_set = 1'b1;
`else
                        state_d     = S_FETCH;
`endif
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
                else           wait_inc = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req  = 1'b1;
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                if (mem_ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end else begin
                    wait_inc = 1'b1;
                end
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                state_d   = S_FETCH;
                retire    = 1'b1;
            end
            S_EXECUTER: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
                state_d = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                state_d  = S_FETCH;
                retire   = 1'b1;
            end
            S_JAL: begin
                ALUSrcA  = 2'b01;
                ALUSrcB  = 2'b10;
                PCUpdate = 1'b1;
                state_d  = S_ALUWB;
            end
            S_BEQ: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b01;
                Branch  = 1'b1;
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_FETCH;
        endcase

        // A stalled memory state either keeps counting or, at the limit, faults.
        if (wait_inc && timeout_hit) begin
            state_d  = S_FAULT;
            to_fault = 1'b1;
        end
        if (wait_inc && (state_d == state_q)) begin
            wait_d = wait_q + TO_CNT_W'(1);
        end
    end

    // Immediate format follows the opcode directly.
    always_comb begin
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

endmodule
